// File: rtl/rf_exec_ctrl_pkg.sv
// Shared definitions for the register-file execution controller: opcodes,
// FSM state encoding and instruction field positions.
package rf_exec_ctrl_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  // Instruction word: op[15:12] wr_addr[11:9] rs_a[8:6] rs_b[5:3]; LDI imm9 = [8:0]
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int WA_MSB  = 11;
  localparam int WA_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/rf_exec_ctrl_alu16.sv
// Combinational 16-bit ALU: result plus carry/zero for every legal opcode.
module alu16
  import rf_exec_ctrl_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
  input  logic [8:0]  imm9,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  logic [16:0] sum17;

  always_comb begin
    sum17  = {1'b0, a} + {1'b0, b};
    result = 16'd0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum17[15:0];
        carry  = sum17[16];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[14:0], 1'b0};
        carry  = a[15];
      end
      OP_SHR: begin
        result = {1'b0, a[15:1]};
        carry  = a[0];
      end
      OP_LDI: result = {7'd0, imm9};
      OP_MOV: result = a;
      default: begin
        result = 16'd0;
        carry  = 1'b0;
      end
    endcase
    zero = (result == 16'd0);
  end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Four-state controller that fetches operands from an external register file,
// executes one ALU operation and writes the result back.
module rf_exec_ctrl
  import rf_exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  input  logic [WIDTH-1:0] d_out_a,
  input  logic [WIDTH-1:0] d_out_b,
  output logic             wr,
  output logic [2:0]       wr_addr,
  output logic [WIDTH-1:0] d_in,
  output logic             done,
  output logic             err,
  output logic             zero,
  output logic             carry,
  output state_e           dbg_state
);

  // Handshake: instr is taken on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, so instr is ignored in all other states.

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;

  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        legal;

  assign legal = op_legal(instr_q[OP_MSB:OP_LSB]);

  alu16 u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (instr_q[OP_MSB:OP_LSB]),
    .imm9   (instr_q[IMM_MSB:IMM_LSB]),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        a_d     = d_out_a;
        b_d     = d_out_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Illegal opcodes leave result and flags untouched.
        if (legal) begin
          result_d = alu_result;
          zero_d   = alu_zero;
          carry_d  = alu_carry;
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= 16'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      result_q <= 16'd0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  // Strobes decode only registered state so they cannot glitch.
  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_WB);
  assign wr          = (state_q == ST_WB) && legal;
  assign err         = (state_q == ST_WB) && !legal;
  assign rd_addr_a   = instr_q[RA_MSB:RA_LSB];
  assign rd_addr_b   = instr_q[RB_MSB:RB_LSB];
  assign wr_addr     = instr_q[WA_MSB:WA_LSB];
  assign d_in        = result_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Bench for rf_exec_ctrl with a behavioural register file and a reference model
// feeding an expected-result queue.
module tb_rf_exec_ctrl;
  import rf_exec_ctrl_pkg::*;

  localparam int EW = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] d_out_a, d_out_b;
  logic        wr;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        done, err, zero, carry;
  state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {is_err, wr, wr_addr, d_in, zero, carry}
  logic [EW-1:0] exp_q[$];
  logic [15:0]   m_rf[8];
  logic          m_zero, m_carry;
  logic [15:0]   rf[8];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  rf_exec_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .d_out_a     (d_out_a),
    .d_out_b     (d_out_b),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .done        (done),
    .err         (err),
    .zero        (zero),
    .carry       (carry),
    .dbg_state   (dbg_state)
  );

  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  always @(posedge clk) begin
    if (wr) rf[wr_addr] <= d_in;
  end

  // ---------------- reference model ----------------
  function automatic logic [16:0] exp_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [8:0] imm);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {(a < b), a - b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, ~a};
      4'd6: return {a[15], a << 1};
      4'd7: return {a[0], a >> 1};
      4'd8: return {8'd0, imm};
      4'd9: return {1'b0, a};
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] wa,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, wa, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [2:0] wa, input logic [8:0] imm);
    return {4'd8, wa, imm};
  endfunction

  function automatic logic [EW-1:0] predict(input logic [15:0] ins);
    logic [16:0] r;
    if (ins[15:12] <= 4'd9) begin
      r = exp_alu(ins[15:12], m_rf[ins[8:6]], m_rf[ins[5:3]], ins[8:0]);
      return {1'b0, 1'b1, ins[11:9], r[15:0], (r[15:0] == 16'd0), r[16]};
    end
    return {1'b1, 1'b0, 3'd0, 16'd0, m_zero, m_carry};
  endfunction

  function automatic void model_commit(input logic [15:0] ins, input logic [EW-1:0] e);
    if (!e[EW-1]) begin
      m_rf[ins[11:9]] = e[17:2];
      m_zero          = e[1];
      m_carry         = e[0];
    end
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic issue(input logic [15:0] ins, output int lat, output int wr_cnt);
    logic [EW-1:0] e, got;
    int wait_n;
    lat = 0;
    wr_cnt = 0;
    instr = ins;
    instr_valid = 1'b1;
    wait_n = 0;
    while (!instr_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!instr_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: instr %h not accepted in 20 cycles", ins);
      instr_valid = 1'b0;
      return;
    end
    e = predict(ins);
    exp_q.push_back(e);
    model_commit(ins, e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (wr) wr_cnt++;
      if (done && lat == 0) begin
        lat = k;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_underflow: done with empty queue, required entry");
        end else begin
          e = exp_q.pop_front();
          if (e[EW-1]) begin
            got = {err, wr, 3'd0, 16'd0, zero, carry};
            e[19:2] = 18'd0;
          end else begin
            got = {err, wr, wr_addr, d_in, zero, carry};
          end
          if (got !== e) $display("FAIL sb_result: instr %h got %h want %h", ins, got, e);
          else n_pass++;
        end
      end
    end
    if (lat == 0) begin
      n_checks++;
      $display("FAIL done_timeout: instr %h got no done, required within 4 cycles", ins);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", instr_ready);
    else n_pass++;
    n_checks++;
    if ({wr, done, err} !== 3'b000) $display("FAIL rst_strobes: got %b want 000", {wr, done, err});
    else n_pass++;
    n_checks++;
    if ({zero, carry} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {zero, carry});
    else n_pass++;
    n_checks++;
    if ({rd_addr_a, rd_addr_b, wr_addr, d_in} !== 25'd0)
      $display("FAIL rst_addr_data: got %h want 0", {rd_addr_a, rd_addr_b, wr_addr, d_in});
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d want 0", dbg_state);
    else n_pass++;
    m_zero = 1'b0;
    m_carry = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi();
    int lat, wc;
    issue(mk_ldi(3'd1, 9'd300), lat, wc);
    n_checks++;
    if (lat !== 3) $display("FAIL ldi_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (wc !== 1) $display("FAIL ldi_wr_width: got %0d want 1", wc);
    else n_pass++;
    issue(mk_ldi(3'd2, 9'd45), lat, wc);
    n_checks++;
    if (lat !== 3 || wc !== 1) $display("FAIL ldi2_timing: got lat %0d wr %0d want 3 1", lat, wc);
    else n_pass++;
    n_checks++;
    if (rf[1] !== 16'd300 || rf[2] !== 16'd45)
      $display("FAIL ldi_regs: got r1=%0d r2=%0d want 300 45", rf[1], rf[2]);
    else n_pass++;
  endtask

  task automatic test_add_sub();
    int lat, wc;
    issue(mk(OP_ADD, 3'd3, 3'd1, 3'd2), lat, wc);
    n_checks++;
    if (rf[3] !== 16'd345 || zero !== 1'b0 || carry !== 1'b0)
      $display("FAIL add: got r3=%0d z=%b c=%b want 345 0 0", rf[3], zero, carry);
    else n_pass++;
    issue(mk(OP_SUB, 3'd4, 3'd2, 3'd1), lat, wc);
    n_checks++;
    if (rf[4] !== 16'hFF01 || carry !== 1'b1)
      $display("FAIL sub_borrow: got r4=%h c=%b want ff01 1", rf[4], carry);
    else n_pass++;
  endtask

  task automatic test_shift_xor();
    int lat, wc;
    issue(mk_ldi(3'd5, 9'd511), lat, wc);
    for (int i = 0; i < 7; i++) issue(mk(OP_SHL, 3'd5, 3'd5, 3'd0), lat, wc);
    n_checks++;
    if (rf[5] !== 16'hFF80) $display("FAIL shl_chain: got %h want ff80", rf[5]);
    else n_pass++;
    issue(mk(OP_ADD, 3'd6, 3'd5, 3'd5), lat, wc);
    n_checks++;
    if (rf[6] !== 16'hFF00 || carry !== 1'b1)
      $display("FAIL add_carry: got r6=%h c=%b want ff00 1", rf[6], carry);
    else n_pass++;
    issue(mk(OP_XOR, 3'd7, 3'd3, 3'd3), lat, wc);
    n_checks++;
    if (rf[7] !== 16'd0 || zero !== 1'b1)
      $display("FAIL xor_zero: got r7=%h z=%b want 0 1", rf[7], zero);
    else n_pass++;
    issue(mk(OP_SHR, 3'd7, 3'd4, 3'd0), lat, wc);
    n_checks++;
    if (rf[7] !== 16'h7F80 || carry !== 1'b1)
      $display("FAIL shr: got r7=%h c=%b want 7f80 1", rf[7], carry);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [EW-1:0] e, got;
    logic [15:0]   ins;
    int accepts, dones, wrs;
    logic          z0, c0;
    z0 = zero;
    c0 = carry;
    accepts = 0;
    dones = 0;
    wrs = 0;
    ins = {4'd12, 12'($urandom)};
    instr = ins;
    instr_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (instr_ready) begin
        accepts++;
        e = predict(ins);
        exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (wr) wrs++;
      n_checks++;
      if (instr_ready !== (dbg_state == ST_IDLE))
        $display("FAIL ill_ready: got ready %b in state %0d", instr_ready, dbg_state);
      else n_pass++;
      if (done) begin
        dones++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL ill_underflow: done with empty queue");
        end else begin
          e = exp_q.pop_front();
          e[19:2] = 18'd0;
          got = {err, wr, 3'd0, 16'd0, zero, carry};
          if (got !== e) $display("FAIL ill_result: got %h want %h", got, e);
          else n_pass++;
        end
      end
    end
    instr_valid = 1'b0;
    n_checks++;
    if (accepts !== 2 || dones !== 2 || wrs !== 0)
      $display("FAIL ill_counts: got acc %0d done %0d wr %0d want 2 2 0", accepts, dones, wrs);
    else n_pass++;
    n_checks++;
    if (zero !== z0 || carry !== c0)
      $display("FAIL ill_flags: got %b%b want %b%b", zero, carry, z0, c0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [15:0] r3_before;
    r3_before = rf[3];
    instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_EXEC) $display("FAIL mid_in_exec: got state %0d want 2", dbg_state);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_IDLE || wr !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_abort: got state %0d wr %b done %b want 0 0 0", dbg_state, wr, done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    m_zero = 1'b0;
    m_carry = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", instr_ready);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wr || done) bad++;
    end
    n_checks++;
    if (bad !== 0 || rf[3] !== r3_before)
      $display("FAIL mid_no_write: got strobes %0d r3=%h want 0 %h", bad, rf[3], r3_before);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, wc;
    issue(mk(OP_MOV, 3'd2, 3'd1, 3'd0), lat, wc);
    issue(mk(OP_ADD, 3'd3, 3'd2, 3'd2), lat, wc);
    n_checks++;
    if (rf[3] !== 16'd600) $display("FAIL b2b_hazard: got %0d want 600", rf[3]);
    else n_pass++;
    issue(mk(OP_ADD, 3'd1, 3'd1, 3'd2), lat, wc);
    n_checks++;
    if (rf[1] !== 16'd600) $display("FAIL self_rw: got %0d want 600", rf[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, wc;
    for (int i = 0; i < 16; i++) begin
      issue(mk(4'($urandom_range(0, 9)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))), lat, wc);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rf[i] !== m_rf[i]) $display("FAIL rf_final r%0d: got %h want %h", i, rf[i], m_rf[i]);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    instr = 16'd0;
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'd0;
      m_rf[i] = 16'd0;
    end
    m_zero = 1'b0;
    m_carry = 1'b0;
    @(negedge clk);
    test_reset();
    test_ldi();
    test_add_sub();
    test_shift_xor();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
